// File: rtl/delayer_var_reg_based.sv
// -----------------------------------------------------------------------------
// delayer_var_reg_based
//
// Register-based delay line with a run-time programmable delay of 1..SIZE
// cycles. A beat accepted on val_i is presented once on val_o/dat_o after the
// active delay (dly_o) of enabled cycles. The line supports stall (ena_i),
// flush, an in-flight beat counter and an optional sticky error flag.
// Data registers only load on valid beats so idle payload bits do not toggle.
//
// Optional feature macro: DELAYER_VAR_ERR_CHK_EN
//   defined   : err_o latches protocol errors (val_i while stalled, rejected
//               cfg_upd_i) until flush_i or reset. With SIM_KNOB_DBG also
//               defined, each error event prints a simulation message.
//   undefined : err_o is tied low and no detection logic exists.
//
// Ports:
//   clk        clock, all logic on rising edge
//   rstn       synchronous active-low reset
//   cfg_dly_i  requested delay (0 loads 1, above SIZE loads SIZE)
//   cfg_upd_i  pulse: load cfg_dly_i, honoured only while idle and val_i=0
//   ena_i      advance enable; 0 freezes the line
//   flush_i    drop every in-flight beat (highest priority)
//   val_i      input beat valid
//   dat_i      input payload
//   val_o      output beat valid
//   dat_o      output payload (don't-care while val_o=0)
//   dly_o      active delay
//   cnt_o      number of in-flight valid beats
//   bsy_o      cnt_o != 0
//   err_o      sticky protocol-error flag
// -----------------------------------------------------------------------------
module delayer_var_reg_based #(
    parameter int  SIZE    = 8,
    parameter int  DATA_WD = 32,
    parameter int  DLY_RST = 8,
    localparam int DLY_WD  = $clog2(SIZE + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [DLY_WD-1:0]  cfg_dly_i,
    input  logic               cfg_upd_i,
    input  logic               ena_i,
    input  logic               flush_i,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    output logic               val_o,
    output logic [DATA_WD-1:0] dat_o,
    output logic [DLY_WD-1:0]  dly_o,
    output logic [DLY_WD-1:0]  cnt_o,
    output logic               bsy_o,
    output logic               err_o
);

    logic [SIZE-1:0]    vstage_r;
    logic [SIZE-1:0]    vstage_nxt_s;
    logic [SIZE-1:0]    live_s;
    logic [SIZE-1:0]    tap_sel_s;
    logic [SIZE-1:0]    dld_s;
    logic [DATA_WD-1:0] dstage_r [SIZE];
    logic [DLY_WD-1:0]  dly_r;
    logic [DLY_WD-1:0]  dly_nxt_s;
    logic [DLY_WD-1:0]  cnt_r;
    logic [DLY_WD-1:0]  cnt_nxt_s;
    logic               tap_v_s;
    logic [DATA_WD-1:0] tap_d_s;
    logic               val_s;
    logic               acc_s;
    logic               bsy_s;
    logic               upd_ok_s;

    // Saturate a requested delay into the legal 1..SIZE window.
    function automatic logic [DLY_WD-1:0] clamp_dly(input logic [DLY_WD-1:0] req);
        logic [DLY_WD-1:0] res;
        if (req == {DLY_WD{1'b0}}) begin
            res = DLY_WD'(1'b1);
        end else if (req > DLY_WD'(SIZE)) begin
            res = DLY_WD'(SIZE);
        end else begin
            res = req;
        end
        return res;
    endfunction

    // Decode the active delay into a live-stage mask and a one-hot output tap.
    always_comb begin
        live_s    = {SIZE{1'b0}};
        tap_sel_s = {SIZE{1'b0}};
        tap_v_s   = 1'b0;
        tap_d_s   = {DATA_WD{1'b0}};
        for (int k = 0; k < SIZE; k++) begin
            live_s[k]    = (DLY_WD'(k) < dly_r);
            tap_sel_s[k] = (DLY_WD'(k) == (dly_r - DLY_WD'(1'b1)));
            tap_v_s      = tap_v_s | (vstage_r[k] & tap_sel_s[k]);
            tap_d_s      = tap_d_s | (tap_sel_s[k] ? dstage_r[k] : {DATA_WD{1'b0}});
        end
    end

    // Next-state for valid stages, data-load strobes, counter and delay.
    always_comb begin
        bsy_s    = (cnt_r != {DLY_WD{1'b0}});
        acc_s    = val_i & ena_i & ~flush_i;
        // rstn gates val_o so nothing is presented in a reset cycle.
        val_s    = tap_v_s & ena_i & ~flush_i & rstn;
        upd_ok_s = cfg_upd_i & ~flush_i & ~bsy_s & ~val_i;

        vstage_nxt_s = vstage_r;
        dld_s        = {SIZE{1'b0}};
        if (flush_i) begin
            vstage_nxt_s = {SIZE{1'b0}};
        end else if (ena_i) begin
            vstage_nxt_s[0] = val_i;
            dld_s[0]        = val_i;
            // Beats leaving stage D-1 are dropped, so stages >= D stay clear
            // and a later, larger delay never exposes stale valid bits.
            for (int k = 1; k < SIZE; k++) begin
                vstage_nxt_s[k] = vstage_r[k-1] & live_s[k];
                dld_s[k]        = vstage_r[k-1] & live_s[k];
            end
        end else begin
            vstage_nxt_s = vstage_r;
        end

        if (flush_i) begin
            cnt_nxt_s = {DLY_WD{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + DLY_WD'(acc_s) - DLY_WD'(val_s);
        end

        if (upd_ok_s) begin
            dly_nxt_s = clamp_dly(cfg_dly_i);
        end else begin
            dly_nxt_s = dly_r;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vstage_r <= {SIZE{1'b0}};
            cnt_r    <= {DLY_WD{1'b0}};
            dly_r    <= DLY_WD'(DLY_RST);
        end else begin
            vstage_r <= vstage_nxt_s;
            cnt_r    <= cnt_nxt_s;
            dly_r    <= dly_nxt_s;
        end
    end

    // Payload stages: no reset, load only when a valid beat moves in.
    always_ff @(posedge clk) begin
        if (dld_s[0]) begin
            dstage_r[0] <= dat_i;
        end
        for (int k = 1; k < SIZE; k++) begin
            if (dld_s[k]) begin
                dstage_r[k] <= dstage_r[k-1];
            end
        end
    end

    assign val_o = val_s;
    assign dat_o = tap_d_s;
    assign dly_o = dly_r;
    assign cnt_o = cnt_r;
    assign bsy_o = bsy_s;

`ifdef DELAYER_VAR_ERR_CHK_EN
    logic err_r;
    logic err_evt_s;

    // Error events; a flush cycle drops its inputs silently.
    always_comb begin
        err_evt_s = 1'b0;
        if (flush_i) begin
            err_evt_s = 1'b0;
        end else begin
            err_evt_s = (val_i & ~ena_i) | (cfg_upd_i & (bsy_s | val_i));
        end
    end

    // Sticky error flag, cleared by flush or reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_r <= 1'b0;
        end else if (flush_i) begin
            err_r <= 1'b0;
        end else if (err_evt_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

`ifdef SIM_KNOB_DBG
    // Debug trace of each error event.
    always @(posedge clk) begin
        if (rstn && err_evt_s) begin
            $display("%m: protocol error val_i=%0b ena_i=%0b cfg_upd_i=%0b cnt=%0d",
                     val_i, ena_i, cfg_upd_i, cnt_r);
        end
    end
`endif

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_delayer_var_reg_based.sv
// -----------------------------------------------------------------------------
// Testbench for delayer_var_reg_based (SIZE=8, DATA_WD=32, DLY_RST=8).
// A timestamp model tracks every accepted beat with the enable-tick at which it
// is due; a compare process checks all outputs each cycle at the falling edge.
// Directed sequences add literal expectations at hand-computed cycles.
// -----------------------------------------------------------------------------
module tb_delayer_var_reg_based;

`ifdef DELAYER_VAR_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int DLY_RST = 8;

    logic        clk;
    logic        rstn;
    logic [3:0]  cfg_dly_i;
    logic        cfg_upd_i;
    logic        ena_i;
    logic        flush_i;
    logic        val_i;
    logic [31:0] dat_i;
    logic        val_o;
    logic [31:0] dat_o;
    logic [3:0]  dly_o;
    logic [3:0]  cnt_o;
    logic        bsy_o;
    logic        err_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    delayer_var_reg_based #(.SIZE(8), .DATA_WD(32), .DLY_RST(DLY_RST)) dut (
        .clk(clk), .rstn(rstn), .cfg_dly_i(cfg_dly_i), .cfg_upd_i(cfg_upd_i),
        .ena_i(ena_i), .flush_i(flush_i), .val_i(val_i), .dat_i(dat_i),
        .val_o(val_o), .dat_o(dat_o), .dly_o(dly_o), .cnt_o(cnt_o),
        .bsy_o(bsy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] d;
        int          due;
    } beat_t;

    beat_t q[$];
    int    tick  = 0;   // number of enabled edges so far
    int    m_dly = DLY_RST;
    bit    m_err = 1'b0;

    function automatic int clamp(input int c);
        if (c == 0) return 1;
        if (c > 8) return 8;
        return c;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                q.delete();
                m_dly = DLY_RST;
                m_err = 1'b0;
                tick  = 0;
            end else if (flush_i) begin
                q.delete();
                m_err = 1'b0;
            end else begin
                if (cfg_upd_i) begin
                    if (q.size() == 0 && !val_i) m_dly = clamp(int'(cfg_dly_i));
                    else if (ERR_EN) m_err = 1'b1;
                end
                if (val_i && !ena_i && ERR_EN) m_err = 1'b1;
                if (ena_i) begin
                    if (q.size() > 0) begin
                        if (q[0].due == tick) void'(q.pop_front());
                    end
                    if (val_i) q.push_back('{d: dat_i, due: tick + m_dly});
                    tick++;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                bit exp_v;
                exp_v = 1'b0;
                if (rstn && !flush_i && ena_i && q.size() > 0) begin
                    if (q[0].due == tick) exp_v = 1'b1;
                end
                chk("mdl_val", {31'd0, val_o}, {31'd0, exp_v});
                if (exp_v) chk("mdl_dat", dat_o, q[0].d);
                chk("mdl_cnt", {28'd0, cnt_o}, q.size());
                chk("mdl_bsy", {31'd0, bsy_o}, {31'd0, q.size() != 0});
                chk("mdl_dly", {28'd0, dly_o}, m_dly);
                chk("mdl_err", {31'd0, err_o}, {31'd0, m_err});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic r, input logic v, input logic e, input logic f,
                       input logic u, input logic [3:0] c, input logic [31:0] d);
        rstn = r; val_i = v; ena_i = e; flush_i = f; cfg_upd_i = u; cfg_dly_i = c; dat_i = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        cyc();
    endtask

    task automatic cfg(input logic [3:0] c);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, c, 32'd0);
        cyc();
    endtask

    initial begin
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        cyc();
        cyc();
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_val", {31'd0, val_o}, 32'd0);
        chk("rst_cnt", {28'd0, cnt_o}, 32'd0);
        chk("rst_bsy", {31'd0, bsy_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_dly", {28'd0, dly_o}, 32'd8);
        cyc();

        // Burst of 20 beats with the reset delay of 8.
        for (int i = 0; i < 30; i++) begin
            drv(1'b1, i < 20, 1'b1, 1'b0, 1'b0, 4'd0, i);
            @(negedge clk);
            if (i == 7)  chk("burst_pre", {31'd0, val_o}, 32'd0);
            if (i == 8) begin
                chk("burst_first_v", {31'd0, val_o}, 32'd1);
                chk("burst_first_d", dat_o, 32'd0);
                chk("burst_full", {28'd0, cnt_o}, 32'd8);
            end
            if (i == 19) chk("burst_sat", {28'd0, cnt_o}, 32'd8);
            if (i == 27) chk("burst_last_d", dat_o, 32'd19);
            if (i == 28) begin
                chk("burst_end_v", {31'd0, val_o}, 32'd0);
                chk("burst_end_c", {28'd0, cnt_o}, 32'd0);
            end
            cyc();
        end

        // Delay 3, single beat.
        cfg(4'd3);
        for (int j = 0; j < 6; j++) begin
            drv(1'b1, j == 0, 1'b1, 1'b0, 1'b0, 4'd0, 32'hA5);
            @(negedge clk);
            if (j == 0) chk("d3_dly", {28'd0, dly_o}, 32'd3);
            if (j == 2) chk("d3_pre", {31'd0, val_o}, 32'd0);
            if (j == 3) begin
                chk("d3_v", {31'd0, val_o}, 32'd1);
                chk("d3_d", dat_o, 32'hA5);
            end
            if (j == 4) chk("d3_once", {31'd0, val_o}, 32'd0);
            cyc();
        end

        // Request 0 clamps to 1.
        cfg(4'd0);
        for (int j = 0; j < 3; j++) begin
            drv(1'b1, j == 0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h3C);
            @(negedge clk);
            if (j == 0) chk("clamp0_dly", {28'd0, dly_o}, 32'd1);
            if (j == 1) begin
                chk("d1_v", {31'd0, val_o}, 32'd1);
                chk("d1_d", dat_o, 32'h3C);
            end
            if (j == 2) chk("d1_once", {31'd0, val_o}, 32'd0);
            cyc();
        end

        // Request 15 clamps to 8.
        cfg(4'd15);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("clamp15_dly", {28'd0, dly_o}, 32'd8);
        cyc();

        // Delay 4, three beats, 5-cycle stall.
        cfg(4'd4);
        for (int j = 0; j < 14; j++) begin
            drv(1'b1, j < 3, !(j >= 3 && j <= 7), 1'b0, 1'b0, 4'd0, j + 1);
            @(negedge clk);
            if (j == 5) begin
                chk("stall_cnt", {28'd0, cnt_o}, 32'd3);
                chk("stall_v", {31'd0, val_o}, 32'd0);
            end
            if (j == 8)  chk("stall_resume", {31'd0, val_o}, 32'd0);
            if (j == 9)  chk("stall_d1", dat_o, 32'd1);
            if (j == 10) chk("stall_d2", dat_o, 32'd2);
            if (j == 11) begin
                chk("stall_v3", {31'd0, val_o}, 32'd1);
                chk("stall_d3", dat_o, 32'd3);
            end
            if (j == 12) chk("stall_cnt_end", {28'd0, cnt_o}, 32'd0);
            cyc();
        end

        // Delay 5, four beats, rejected update then flush with a beat.
        cfg(4'd5);
        for (int j = 0; j < 16; j++) begin
            drv(1'b1, j <= 4, 1'b1, j == 4, j == 3, 4'd2, 32'h10 + j);
            @(negedge clk);
            if (j == 3) chk("fl_cnt3", {28'd0, cnt_o}, 32'd3);
            if (j == 4) begin
                chk("fl_cnt4", {28'd0, cnt_o}, 32'd4);
                chk("fl_err_set", {31'd0, err_o}, {31'd0, ERR_EN});
                chk("fl_v", {31'd0, val_o}, 32'd0);
            end
            if (j == 5) begin
                chk("fl_cnt0", {28'd0, cnt_o}, 32'd0);
                chk("fl_bsy", {31'd0, bsy_o}, 32'd0);
                chk("fl_err_clr", {31'd0, err_o}, 32'd0);
                chk("fl_dly", {28'd0, dly_o}, 32'd5);
            end
            if (j >= 5) chk("fl_quiet", {31'd0, val_o}, 32'd0);
            cyc();
        end

        // Update rejected while two beats in flight.
        for (int j = 0; j < 13; j++) begin
            drv(1'b1, j < 2, 1'b1, 1'b0, j == 2, 4'd2, 32'h20 + j);
            @(negedge clk);
            if (j == 2) chk("rej_cnt", {28'd0, cnt_o}, 32'd2);
            if (j == 3) begin
                chk("rej_dly", {28'd0, dly_o}, 32'd5);
                chk("rej_err", {31'd0, err_o}, {31'd0, ERR_EN});
            end
            if (j == 5) chk("rej_d0", dat_o, 32'h20);
            if (j == 6) chk("rej_d1", dat_o, 32'h21);
            if (j == 12) chk("rej_sticky", {31'd0, err_o}, {31'd0, ERR_EN});
            cyc();
        end
        drv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
        cyc();

        // Beat offered while stalled is dropped.
        for (int j = 0; j < 12; j++) begin
            drv(1'b1, j == 0, j != 0, 1'b0, 1'b0, 4'd0, 32'h77);
            @(negedge clk);
            chk("stv_none", {31'd0, val_o}, 32'd0);
            if (j == 1) begin
                chk("stv_err", {31'd0, err_o}, {31'd0, ERR_EN});
                chk("stv_cnt", {28'd0, cnt_o}, 32'd0);
            end
            cyc();
        end
        drv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
        cyc();
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("stv_err_clr", {31'd0, err_o}, 32'd0);
        cyc();

        // Delay 6 stream interrupted by a one-cycle reset.
        cfg(4'd6);
        for (int j = 0; j < 18; j++) begin
            drv(j != 7, (j <= 6) || (j == 8), 1'b1, 1'b0, 1'b0, 4'd0,
                (j == 8) ? 32'h5A : 32'h40 + j);
            @(negedge clk);
            if (j == 6) begin
                chk("rs_first_v", {31'd0, val_o}, 32'd1);
                chk("rs_first_d", dat_o, 32'h40);
                chk("rs_dly6", {28'd0, dly_o}, 32'd6);
            end
            if (j == 7) chk("rs_cycle_v", {31'd0, val_o}, 32'd0);
            if (j == 8) begin
                chk("rs_v", {31'd0, val_o}, 32'd0);
                chk("rs_cnt", {28'd0, cnt_o}, 32'd0);
                chk("rs_dly", {28'd0, dly_o}, 32'd8);
            end
            if (j == 15) chk("rs_pre", {31'd0, val_o}, 32'd0);
            if (j == 16) begin
                chk("rs_next_v", {31'd0, val_o}, 32'd1);
                chk("rs_next_d", dat_o, 32'h5A);
            end
            if (j == 17) chk("rs_once", {31'd0, val_o}, 32'd0);
            cyc();
        end

        idle_cyc();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
